// File: rtl/jtdsp16_pio_host_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtdsp16_pio_host_if                                                  |
// | DSP16 parallel-port strobes and host register bus bundle.            |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
interface jtdsp16_pio_host_if;
  logic        cen;
  logic [15:0] dsp_pbus;
  logic        pods_n;
  logic        pids_n;
  logic        psel;
  logic [15:0] pbus_in;
  logic        dsp_irq;
  logic [ 1:0] host_addr;
  logic        host_we;
  logic        host_re;
  logic [15:0] host_din;
  logic [15:0] host_dout;

  modport master (
    output cen, dsp_pbus, pods_n, pids_n, psel,
    output host_addr, host_we, host_re, host_din,
    input  pbus_in, dsp_irq, host_dout
  );

  modport slave (
    input  cen, dsp_pbus, pods_n, pids_n, psel,
    input  host_addr, host_we, host_re, host_din,
    output pbus_in, dsp_irq, host_dout
  );
endinterface
`default_nettype wire

// File: rtl/jtdsp16_pio_host.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | jtdsp16_pio_host                                                     |
// | Host-side responder for the DSP16 parallel port in active mode.      |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module jtdsp16_pio_host #(
  parameter int AW = 2
) (
  input wire logic           clk,
  input wire logic           rst,
  jtdsp16_pio_host_if.slave  bus
);

  localparam int            c_DEPTH = 1 << AW;
  localparam logic [AW:0]   c_FULL  = (AW+1)'(c_DEPTH);

  logic        r_last_pods;
  logic        r_last_pids;
  logic        r_ovf;
  logic        r_unf;
  logic        r_irq_en;
  logic        r_irq;
  logic [15:0] r_host_dout;

  logic        w_wr_end;
  logic        w_rd_end;
  logic        w_host_rd;
  logic        w_ctrl_wr;
  logic [1:0]  w_full;
  logic [1:0]  w_nempty;
  logic [1:0]  w_drop;
  logic [1:0]  w_hvalid;
  logic [15:0] w_head [0:1];
  logic [15:0] w_hold [0:1];
  logic [15:0] w_status;

  // Only the rising edge of a strobe matters, sampled on DSP phase enables
  assign w_wr_end  = bus.cen & bus.pods_n & ~r_last_pods;
  assign w_rd_end  = bus.cen & bus.pids_n & ~r_last_pids;
  // A simultaneous write takes precedence and suppresses the read
  assign w_host_rd = bus.host_re & ~bus.host_we;
  assign w_ctrl_wr = bus.host_we & (bus.host_addr == 2'd2);

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    localparam bit c_CH = (gi != 0);

    logic [15:0]   r_mem [0:c_DEPTH-1];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [15:0]   r_hold;
    logic          r_hvalid;
    logic          w_sel;
    logic          w_push_req;
    logic          w_push;
    logic          w_pop;
    logic          w_hwr;

    assign w_sel       = (bus.psel == c_CH);
    assign w_full[gi]  = (r_count == c_FULL);
    assign w_nempty[gi]= (r_count != '0);
    assign w_pop       = w_host_rd & (bus.host_addr == 2'(gi)) & w_nempty[gi];
    assign w_push_req  = w_wr_end & w_sel;
    // A pop in the same clk frees the slot a full FIFO needs
    assign w_push      = w_push_req & (~w_full[gi] | w_pop);
    assign w_drop[gi]  = w_push_req & w_full[gi] & ~w_pop;
    assign w_head[gi]  = r_mem[r_rptr];
    assign w_hwr       = bus.host_we & (bus.host_addr == 2'(gi));
    assign w_hold[gi]  = r_hold;
    assign w_hvalid[gi]= r_hvalid;

    always_ff @(posedge clk) begin
      if (w_push) begin
        r_mem[r_wptr] <= bus.dsp_pbus;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_wptr <= r_wptr + 1'b1;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_hold   <= '0;
        r_hvalid <= 1'b0;
      end else if (w_hwr) begin
        r_hold   <= bus.host_din;
        r_hvalid <= 1'b1;
      end else if (w_rd_end && w_sel) begin
        r_hvalid <= 1'b0;
      end
    end
  end

  assign w_status = {7'd0, r_irq_en, r_unf, r_ovf, w_hvalid[1], w_hvalid[0],
                     w_full, w_nempty};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_pods <= 1'b1;
      r_last_pids <= 1'b1;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_irq_en    <= 1'b0;
      r_irq       <= 1'b0;
      r_host_dout <= '0;
    end else begin
      if (bus.cen) begin
        r_last_pods <= bus.pods_n;
        r_last_pids <= bus.pids_n;
      end
      // Set events win over a coincident host clear
      r_ovf <= (r_ovf & ~(w_ctrl_wr & bus.host_din[6])) | (|w_drop);
      r_unf <= (r_unf & ~(w_ctrl_wr & bus.host_din[7]))
             | (w_rd_end & ~w_hvalid[bus.psel]);
      if (w_ctrl_wr) begin
        r_irq_en <= bus.host_din[8];
      end
      r_irq <= r_irq_en & (|w_hvalid);
      if (w_host_rd) begin
        case (bus.host_addr)
          2'd0:    r_host_dout <= w_nempty[0] ? w_head[0] : 16'd0;
          2'd1:    r_host_dout <= w_nempty[1] ? w_head[1] : 16'd0;
          2'd2:    r_host_dout <= w_status;
          default: r_host_dout <= 16'd0;
        endcase
      end
    end
  end

  assign bus.pbus_in   = bus.psel ? w_hold[1] : w_hold[0];
  assign bus.dsp_irq   = r_irq;
  assign bus.host_dout = r_host_dout;

endmodule
`default_nettype wire

// File: tb/tb_jtdsp16_pio_host.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_jtdsp16_pio_host                                                  |
// | Scoreboard bench with a queue-based reference model.                 |
// | Revision: 1.0                                                        |
// +--------------------------------------------------------------------+
module tb_jtdsp16_pio_host;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jtdsp16_pio_host_if bus();
  jtdsp16_pio_host #(.AW(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_q0 [$];
  logic [15:0] m_q1 [$];
  logic [15:0] m_hold [2];
  bit          m_hv [2];
  bit          m_ovf, m_unf, m_irq_en, m_prev_pods, m_prev_pids;
  logic [15:0] sb [$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int ch);
    return (ch == 0) ? m_q0.size() : m_q1.size();
  endfunction

  function automatic logic [15:0] m_status();
    return {7'd0, m_irq_en, m_unf, m_ovf, m_hv[1], m_hv[0],
            qsize(1) == 4, qsize(0) == 4, qsize(1) != 0, qsize(0) != 0};
  endfunction

  task automatic model_reset();
    m_q0.delete(); m_q1.delete();
    m_hold[0] = 0; m_hold[1] = 0; m_hv[0] = 0; m_hv[1] = 0;
    m_ovf = 0; m_unf = 0; m_irq_en = 0; m_prev_pods = 1; m_prev_pids = 1;
  endtask

  // One clk: apply the spec rules to the current inputs, then check per-cycle outputs
  task automatic step();
    bit wr, rd, hre, pop0, pop1, set_ovf, set_unf, irq_next, ctrl;
    int ch;
    logic [15:0] exp;
    irq_next = 0;
    if (rst) begin
      model_reset();
    end else begin
      wr   = bus.cen && bus.pods_n && !m_prev_pods;
      rd   = bus.cen && bus.pids_n && !m_prev_pids;
      hre  = bus.host_re && !bus.host_we;
      ch   = int'(bus.psel);
      ctrl = bus.host_we && bus.host_addr == 2'd2;
      pop0 = hre && bus.host_addr == 2'd0 && m_q0.size() > 0;
      pop1 = hre && bus.host_addr == 2'd1 && m_q1.size() > 0;
      if (hre) begin
        case (bus.host_addr)
          2'd0: exp = (m_q0.size() > 0) ? m_q0[0] : 16'd0;
          2'd1: exp = (m_q1.size() > 0) ? m_q1[0] : 16'd0;
          2'd2: exp = m_status();
          default: exp = 16'd0;
        endcase
        sb.push_back(exp);
      end
      irq_next = m_irq_en && (m_hv[0] || m_hv[1]);
      set_ovf  = wr && qsize(ch) == 4 && !(ch == 1 ? pop1 : pop0);
      set_unf  = rd && !m_hv[ch];
      if (pop0) void'(m_q0.pop_front());
      if (pop1) void'(m_q1.pop_front());
      if (wr && !set_ovf) begin
        if (ch == 0) m_q0.push_back(bus.dsp_pbus);
        else         m_q1.push_back(bus.dsp_pbus);
      end
      for (int c = 0; c < 2; c++) begin
        if (bus.host_we && bus.host_addr == 2'(c)) begin
          m_hold[c] = bus.host_din;
          m_hv[c]   = 1;
        end else if (rd && ch == c) begin
          m_hv[c] = 0;
        end
      end
      m_ovf = (m_ovf && !(ctrl && bus.host_din[6])) || set_ovf;
      m_unf = (m_unf && !(ctrl && bus.host_din[7])) || set_unf;
      if (ctrl) m_irq_en = bus.host_din[8];
      if (bus.cen) begin
        m_prev_pods = bus.pods_n;
        m_prev_pids = bus.pids_n;
      end
    end
    @(posedge clk);
    #1;
    chk("dsp_irq", {15'd0, bus.dsp_irq}, {15'd0, irq_next});
    chk("pbus_in", bus.pbus_in, bus.psel ? m_hold[1] : m_hold[0]);
    @(negedge clk);
  endtask

  // Monitor: compares host_dout against the scoreboard the clk after a read
  bit pend = 0;
  always @(posedge clk) pend <= !rst && bus.host_re && !bus.host_we;
  always @(negedge clk) begin
    if (pend) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL host_dout_unexpected actual=%h expected=none", bus.host_dout);
      end else begin
        chk("host_dout", bus.host_dout, sb.pop_front());
      end
    end
  end

  task automatic idle();
    bus.cen = 1; bus.pods_n = 1; bus.pids_n = 1;
    bus.host_we = 0; bus.host_re = 0;
  endtask

  task automatic host_write(input logic [1:0] a, input logic [15:0] d);
    bus.host_we = 1; bus.host_addr = a; bus.host_din = d;
    step();
    bus.host_we = 0;
  endtask

  task automatic host_read(input logic [1:0] a);
    bus.host_re = 1; bus.host_addr = a;
    step();
    bus.host_re = 0;
  endtask

  task automatic dsp_wr(input bit ch, input logic [15:0] d, input int w);
    bus.psel = ch; bus.dsp_pbus = d; bus.pods_n = 0;
    repeat (w) step();
    bus.pods_n = 1;
    step();
  endtask

  task automatic dsp_rd(input bit ch, input int w);
    bus.psel = ch; bus.pids_n = 0;
    repeat (w) step();
    bus.pids_n = 1;
    step();
  endtask

  task automatic do_reset();
    rst = 1;
    step(); step();
    rst = 0;
  endtask

  initial begin
    idle();
    bus.psel = 0; bus.dsp_pbus = 0; bus.host_addr = 0; bus.host_din = 0;
    @(negedge clk);
    do_reset();
    chk("rst_host_dout", bus.host_dout, 16'h0000);
    host_read(2);

    // 1: single write, status, read back
    dsp_wr(0, 16'h1234, 2);
    host_read(2); host_read(0); host_read(2);

    // 2: overflow on channel 1
    for (int i = 1; i <= 5; i++) dsp_wr(1, 16'(i), 1 + i % 3);
    host_read(2);
    for (int i = 0; i < 5; i++) host_read(1);
    host_write(2, 16'h0040); host_read(2);

    // 3: hold write raises irq; DSP read consumes it
    host_write(2, 16'h0100); host_write(1, 16'hBEEF);
    step();
    dsp_rd(1, 3); step(); host_read(2);

    // 4: underrun returns stale hold0
    host_write(0, 16'h5A5A); dsp_rd(0, 1); dsp_rd(0, 2); host_read(2);

    // 5: full FIFO0 with simultaneous push and pop
    for (int i = 0; i < 4; i++) dsp_wr(0, 16'hA000 + 16'(i), 1);
    host_write(2, 16'h0140);
    bus.psel = 0; bus.dsp_pbus = 16'hC0DE; bus.pods_n = 0; step();
    bus.pods_n = 1; bus.host_re = 1; bus.host_addr = 0; step();
    bus.host_re = 0;
    host_read(2);
    for (int i = 0; i < 4; i++) host_read(0);

    // 6: host write coincident with DSP rd_end on channel 0
    host_write(0, 16'h7777);
    bus.psel = 0; bus.pids_n = 0; step();
    bus.pids_n = 1; bus.host_we = 1; bus.host_addr = 0; bus.host_din = 16'h0001; step();
    bus.host_we = 0;
    host_read(2); step();

    // Randomised traffic, including a reset with a strobe held low
    for (int n = 0; n < 1500; n++) begin
      int op;
      if (n == 700) begin
        bus.pods_n = 0; bus.pids_n = 0; bus.host_we = 0; bus.host_re = 0;
        do_reset();
      end
      bus.cen      = ($urandom_range(0, 3) != 0);
      bus.pods_n   = ($urandom_range(0, 2) != 0);
      bus.pids_n   = ($urandom_range(0, 2) != 0);
      bus.psel     = 1'($urandom_range(0, 1));
      bus.dsp_pbus = 16'($urandom);
      op = $urandom_range(0, 9);
      bus.host_addr = 2'($urandom_range(0, 3));
      bus.host_din  = 16'($urandom);
      bus.host_re   = (op <= 2) || (op == 5);
      bus.host_we   = (op == 3) || (op == 4) || (op == 5);
      step();
    end
    idle();
    step(); step();
    chk("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
